// File: rtl/mux_stream_pkg.sv
// Shared constants for the N-channel stream multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input
//   clog2()                 : constant-evaluable ceil(log2), used to size select/tag fields
package mux_stream_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Minimum 1 so that a degenerate width never appears in a port declaration.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search over a request vector.
// Ports:
//   req        in  N_CH   request per channel
//   ptr        in  SEL_W  highest-priority channel for this search (must be < N_CH)
//   gnt_onehot out N_CH   one-hot grant, zero when no request
//   gnt_idx    out SEL_W  index of the granted channel, zero when no request
//   gnt_any    out 1      at least one request present
module rr_arbiter
   import mux_stream_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned SEL_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt_onehot,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   // One spare bit: ptr + offset reaches at most 2*N_CH-2 before the wrap.
   logic [SEL_W:0] w_pos;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_any    = 1'b0;
      w_pos      = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_pos = {1'b0, ptr} + (SEL_W + 1)'(i);
         if (w_pos >= (SEL_W + 1)'(N_CH)) begin
            w_pos = w_pos - (SEL_W + 1)'(N_CH);
         end
         // Constant inner index keeps the request lookup a plain bit-select.
         for (int unsigned k = 0; k < N_CH; k++) begin
            if (!gnt_any && (w_pos == (SEL_W + 1)'(k)) && req[k]) begin
               gnt_any       = 1'b1;
               gnt_idx       = SEL_W'(k);
               gnt_onehot[k] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mux_n_stream.sv
// N-channel, W-bit registered stream multiplexer with valid/ready handshake.
// Picks one channel per cycle, either by explicit select (MANUAL) or round-robin
// over valid channels (SCAN), and holds the word in a single output register.
// Ports:
//   clk        in   1          clock
//   rst        in   1          synchronous reset, active-high
//   mode       in   1          0 = MANUAL, 1 = SCAN
//   sel        in   SEL_W      channel select (MANUAL only)
//   in_data    in   N_CH*W     channel k at bits [k*W +: W]
//   in_valid   in   N_CH       per-channel valid
//   in_ready   out  N_CH       per-channel accept strobe, one-hot or zero
//   out_data   out  W          registered selected word
//   out_ch     out  SEL_W      channel index of out_data
//   out_valid  out  1          output register holds a word
//   out_ready  in   1          downstream accepts when out_valid & out_ready
module mux_n_stream
   import mux_stream_pkg::*;
#(
   parameter  int unsigned N_CH  = 4,
   parameter  int unsigned W     = 16,
   localparam int unsigned SEL_W = clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

   logic [W-1:0]     r_out_data;
   logic [SEL_W-1:0] r_out_ch;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load;
   logic [N_CH-1:0]  w_scan_oh;
   logic [SEL_W-1:0] w_scan_idx;
   logic             w_scan_any;
   logic [N_CH-1:0]  w_man_oh;
   logic             w_man_any;
   logic [N_CH-1:0]  w_gnt_oh;
   logic [SEL_W-1:0] w_gnt_idx;
   logic             w_gnt_any;
   logic             w_xfer;
   logic [W-1:0]     w_sel_data;

   // Output register is free, or its word leaves on this edge.
   assign w_load = ~r_out_valid | out_ready;

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_rr_arbiter (
      .req        (in_valid),
      .ptr        (r_ptr),
      .gnt_onehot (w_scan_oh),
      .gnt_idx    (w_scan_idx),
      .gnt_any    (w_scan_any)
   );

   // Out-of-range select matches no k, so it never grants.
   always_comb begin
      w_man_oh  = '0;
      w_man_any = 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if ((sel == SEL_W'(k)) && in_valid[k]) begin
            w_man_oh[k] = 1'b1;
            w_man_any   = 1'b1;
         end
      end
   end

   always_comb begin
      if (mode == MODE_SCAN) begin
         w_gnt_oh  = w_scan_oh;
         w_gnt_idx = w_scan_idx;
         w_gnt_any = w_scan_any;
      end else begin
         w_gnt_oh  = w_man_oh;
         w_gnt_idx = sel;
         w_gnt_any = w_man_any;
      end
   end

   assign w_xfer   = w_load & w_gnt_any;
   // Suppressed during reset so no front-end believes a word was taken.
   assign in_ready = (w_load && !rst) ? w_gnt_oh : '0;

   always_comb begin
      w_sel_data = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (w_gnt_idx == SEL_W'(k)) begin
            w_sel_data = in_data[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= '0;
      end else begin
         if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
               r_out_data <= w_sel_data;
               r_out_ch   <= w_gnt_idx;
            end
         end
         // Only a SCAN transfer advances the pointer past the winner.
         if (w_xfer && (mode == MODE_SCAN)) begin
            r_ptr <= (w_gnt_idx == LAST_CH) ? '0 : w_gnt_idx + 1'b1;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_n_stream.sv
// Directed self-checking bench for mux_n_stream: a 4-channel instance for the
// main behaviour and a 5-channel instance whose 3-bit select can name channels
// that do not exist.
module tb_mux_n_stream;

   localparam int unsigned W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel instance
   logic          rst;
   logic          mode;
   logic [1:0]    sel;
   logic [63:0]   in_data;
   logic [3:0]    in_valid;
   logic [3:0]    in_ready;
   logic [15:0]   out_data;
   logic [1:0]    out_ch;
   logic          out_valid;
   logic          out_ready;

   // 5-channel instance
   logic          mode1;
   logic [2:0]    sel1;
   logic [79:0]   in_data1;
   logic [4:0]    in_valid1;
   logic [4:0]    in_ready1;
   logic [15:0]   out_data1;
   logic [2:0]    out_ch1;
   logic          out_valid1;
   logic          out_ready1;

   mux_n_stream #(
      .N_CH (4),
      .W    (W)
   ) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   mux_n_stream #(
      .N_CH (5),
      .W    (W)
   ) u_dut5 (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode1),
      .sel       (sel1),
      .in_data   (in_data1),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .out_data  (out_data1),
      .out_ch    (out_ch1),
      .out_valid (out_valid1),
      .out_ready (out_ready1)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ch_val [4];

   initial begin
      ch_val[0] = 16'hC0C0;
      ch_val[1] = 16'hB1B1;
      ch_val[2] = 16'hA5A5;
      ch_val[3] = 16'hD3D3;
      in_data    = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
      rst        = 1'b1;
      mode       = 1'b0;
      sel        = 2'd0;
      in_valid   = 4'hF;
      out_ready  = 1'b1;
      mode1      = 1'b0;
      sel1       = 3'd0;
      in_data1   = {16'h5004, 16'h5003, 16'h5002, 16'h5001, 16'h5000};
      in_valid1  = 5'h00;
      out_ready1 = 1'b1;

      // Reset held two cycles with every channel valid
      #1 check("rst_ready_pre", 32'(in_ready), 0);
      tick();
      check("rst_ready_c1", 32'(in_ready), 0);
      tick();
      check("rst_ready_c2", 32'(in_ready), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_ch", 32'(out_ch), 0);

      // MANUAL select of channel 2
      rst      = 1'b0;
      sel      = 2'd2;
      in_valid = 4'b0100;
      #1 check("man_ready_sel2", 32'(in_ready), 'h4);
      tick();
      check("man_valid_sel2", 32'(out_valid), 1);
      check("man_data_sel2", 32'(out_data), 'hA5A5);
      check("man_ch_sel2", 32'(out_ch), 2);

      // MANUAL select of an idle channel: no grant, held word drains
      sel = 2'd1;
      #1 check("man_ready_idle", 32'(in_ready), 0);
      tick();
      check("man_valid_drain", 32'(out_valid), 0);

      // Select beyond the channel count on the 5-channel instance
      sel1      = 3'd5;
      in_valid1 = 5'h1F;
      #1 check("oor_ready_sel5", 32'(in_ready1), 0);
      tick();
      check("oor_valid_sel5", 32'(out_valid1), 0);
      sel1 = 3'd7;
      #1 check("oor_ready_sel7", 32'(in_ready1), 0);
      tick();
      check("oor_valid_sel7", 32'(out_valid1), 0);
      sel1 = 3'd4;
      #1 check("ch4_ready", 32'(in_ready1), 'h10);
      tick();
      check("ch4_valid", 32'(out_valid1), 1);
      check("ch4_ch", 32'(out_ch1), 4);
      check("ch4_data", 32'(out_data1), 'h5004);
      in_valid1 = 5'h00;

      // SCAN over all channels from ptr=0: 0,1,2,3 twice, leaving ptr=0
      mode     = 1'b1;
      in_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("scan_all_ch%0d", i), 32'(out_ch), 32'(i % 4));
         check($sformatf("scan_all_data%0d", i), 32'(out_data), 32'(ch_val[i[1:0]]));
      end

      // SCAN over channels 1 and 3 from ptr=0
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("scan_odd_ch%0d", i), 32'(out_ch), (i % 2 == 0) ? 1 : 3);
      end

      // Backpressure: held word stays put while inputs change
      out_ready = 1'b0;
      in_valid  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         in_data = {4{16'h0F0F + 16'(i)}};
         #1 check($sformatf("bp_ready%0d", i), 32'(in_ready), 0);
         tick();
         check($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
         check($sformatf("bp_data%0d", i), 32'(out_data), 'hD3D3);
         check($sformatf("bp_ch%0d", i), 32'(out_ch), 3);
      end
      // Pointer must still be 0 after backpressure
      in_data   = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
      out_ready = 1'b1;
      #1 check("bp_release_ready", 32'(in_ready), 'h1);
      tick();
      check("bp_release_ch", 32'(out_ch), 0);
      check("bp_release_data", 32'(out_data), 'hC0C0);

      // Drain+fill in MANUAL, then switch to SCAN (ptr=1), then reset mid-stream
      mode = 1'b0;
      sel  = 2'd3;
      #1 check("df_man_ready", 32'(in_ready), 'h8);
      tick();
      check("df_man_valid", 32'(out_valid), 1);
      check("df_man_ch", 32'(out_ch), 3);
      check("df_man_data", 32'(out_data), 'hD3D3);
      mode = 1'b1;
      #1 check("df_scan_ready", 32'(in_ready), 'h2);
      tick();
      check("df_scan_ch1", 32'(out_ch), 1);
      check("df_scan_data1", 32'(out_data), 'hB1B1);
      tick();
      check("df_scan_valid2", 32'(out_valid), 1);
      check("df_scan_ch2", 32'(out_ch), 2);
      rst = 1'b1;
      #1 check("midrst_ready", 32'(in_ready), 0);
      tick();
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_data", 32'(out_data), 0);
      check("midrst_ch", 32'(out_ch), 0);
      rst = 1'b0;
      #1 check("post_rst_ready", 32'(in_ready), 'h1);
      tick();
      check("post_rst_valid", 32'(out_valid), 1);
      check("post_rst_ch", 32'(out_ch), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
